// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target exposing a NUM_REGS x 8-bit register file with burst read/write and pointer auto-increment
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADR  = 7'h30,
  parameter int         NUM_REGS = 16,
  parameter int         PTR_W    = 8,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  SDA_i,
  input  logic                  SCL_i,
  output logic                  SDA_t,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  busy
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W:0] NR = (PTR_W+1)'(NUM_REGS);
  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEV     = 4'd1;
  localparam logic [3:0] DEV_ACK = 4'd2;
  localparam logic [3:0] PTR     = 4'd3;
  localparam logic [3:0] PTR_ACK = 4'd4;
  localparam logic [3:0] WR      = 4'd5;
  localparam logic [3:0] WR_ACK  = 4'd6;
  localparam logic [3:0] RD      = 4'd7;
  localparam logic [3:0] RD_ACK  = 4'd8;
  localparam logic [3:0] IGNORE  = 4'd9;
  // [0],[1] synchroniser, [2] history for edge detection
  logic [2:0]       sda_q, sda_d, scl_q, scl_d;
  logic [3:0]       state_q, state_d, cnt_q, cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, wr_index_q, wr_index_d;
  logic             rw_q, rw_d, ack_q, ack_d, sda_t_q, sda_t_d;
  logic             busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];
  logic             scl_rise, scl_fall, start_ev, stop_ev, in_rng;
  logic [7:0]       byte_in, rd_byte, rd_bits;
  logic [PTR_W-1:0] ptr_inc;
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_ev = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_ev  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign byte_in  = {sr_q[6:0], sda_q[1]};
  assign in_rng   = {1'b0, ptr_q} < NR;
  assign ptr_inc  = ({1'b0, ptr_q} >= NR - 1'b1) ? '0 : ptr_q + 1'b1;
  assign rd_byte  = in_rng ? regs_q[ptr_q[IW-1:0]] : 8'hFF;
  // a fresh read byte is fetched when no bits of it have been shifted out yet
  assign rd_bits  = (cnt_q == 4'd0) ? rd_byte : sr_q;
  always_comb begin
    sda_d       = {sda_q[1:0], SDA_i};
    scl_d       = {scl_q[1:0], SCL_i};
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_t_d     = sda_t_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    regs_d      = regs_q;
    if (start_ev) begin
      state_d = DEV;
      cnt_d   = '0;
      sda_t_d = 1'b1;
    end else if (stop_ev) begin
      state_d = IDLE;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        DEV: if (scl_rise) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            ack_d = 1'b0;
            if (sr_q[6:0] == I2C_ADR) begin
              rw_d    = sda_q[1];
              busy_d  = 1'b1;
              state_d = DEV_ACK;
            end else state_d = IGNORE;
          end
        end
        PTR, WR: if (scl_rise) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            ack_d = 1'b0;
            if (state_q == PTR) begin
              ptr_d   = PTR_W'(byte_in);
              state_d = PTR_ACK;
            end else begin
              if (in_rng) begin
                regs_d[ptr_q[IW-1:0]] = byte_in;
                wr_strobe_d = 1'b1;
                wr_index_d  = ptr_q;
              end
              ptr_d   = ptr_inc;
              state_d = WR_ACK;
            end
          end
        end
        DEV_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            sda_t_d = 1'b0;
            ack_d   = 1'b1;
          end else begin
            sda_t_d = 1'b1;
            cnt_d   = '0;
            state_d = (state_q == DEV_ACK) ? (rw_q ? RD : PTR) : WR;
            if (state_q == DEV_ACK && rw_q) begin
              sda_t_d = rd_bits[7];
              sr_d    = {rd_bits[6:0], 1'b1};
              cnt_d   = 4'd1;
            end
          end
        end
        RD: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_t_d = 1'b1;
            state_d = RD_ACK;
          end else begin
            sda_t_d = rd_bits[7];
            sr_d    = {rd_bits[6:0], 1'b1};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_q[1]) begin
            ptr_d   = ptr_inc;
            cnt_d   = '0;
            state_d = RD;
          end else state_d = IGNORE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sda_q       <= 3'b111;
      scl_q       <= 3'b111;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      sda_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      regs_q      <= '{default: RST_VAL};
    end else begin
      sda_q       <= sda_d;
      scl_q       <= scl_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_t_q     <= sda_t_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      regs_q      <= regs_d;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) assign regs_o[8*i +: 8] = regs_q[i];
  assign SDA_t     = sda_t_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master driving the register-file target with directed vectors
module tb_i2c_slave_regfile;
  localparam int Q = 15;
  logic         clock = 1'b0, reset_n = 1'b0, sda_m = 1'b1, scl = 1'b1;
  logic         SDA_t, wr_strobe, busy;
  logic [127:0] regs_o;
  logic [7:0]   wr_index;
  logic         sda_bus;
  int           tests = 0, fails = 0;
  int           strobes = 0, sda_low_cnt = 0, busy_cnt = 0;
  logic [7:0]   idx_log [$];
  logic [7:0]   mdl [16];
  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic       strobe;
  } wv_t;
  wv_t wv [7];
  assign sda_bus = sda_m & SDA_t;
  always #5 clock = ~clock;
  i2c_slave_regfile dut (
    .clock(clock), .reset_n(reset_n), .SDA_i(sda_bus), .SCL_i(scl),
    .SDA_t(SDA_t), .regs_o(regs_o), .wr_strobe(wr_strobe),
    .wr_index(wr_index), .busy(busy)
  );
  always @(negedge clock) begin
    if (wr_strobe) begin
      strobes++;
      idx_log.push_back(wr_index);
    end
    if (!SDA_t) sda_low_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] flat();
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = mdl[k];
    return f;
  endfunction
  task automatic qtr();
    repeat (Q) @(negedge clock);
  endtask
  task automatic bitx(input logic b, output logic r);
    sda_m = b; qtr();
    scl = 1'b1; qtr();
    r = sda_bus; qtr();
    scl = 1'b0; qtr();
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; qtr();
    scl = 1'b1; qtr();
    sda_m = 1'b0; qtr();
    scl = 1'b0; qtr();
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; qtr();
    scl = 1'b1; qtr();
    sda_m = 1'b1; qtr();
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(d[i], r);
    bitx(1'b1, r);
    ack = ~r;
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin
      bitx(1'b1, r);
      d = {d[6:0], r};
    end
    bitx(nack, r);
  endtask
  initial begin
    logic a, r;
    logic [7:0] d;
    int s0, n0, l0, b0;
    wv[0] = '{8'h00, 8'h12, 1'b1};
    wv[1] = '{8'h0F, 8'hF0, 1'b1};
    wv[2] = '{8'h07, 8'h81, 1'b1};
    wv[3] = '{8'h20, 8'h77, 1'b0};
    wv[4] = '{8'h10, 8'h99, 1'b0};
    wv[5] = '{8'h0E, 8'h11, 1'b1};
    wv[6] = '{8'h0F, 8'h22, 1'b1};
    for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst SDA_t", 128'(SDA_t), 128'd1);
    chk("rst busy", 128'(busy), 128'd0);
    chk("rst wr_strobe", 128'(wr_strobe), 128'd0);
    chk("rst wr_index", 128'(wr_index), 128'd0);
    chk("rst regs", regs_o, 128'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    // write burst
    s0 = strobes; n0 = idx_log.size();
    i2c_start();
    wbyte(8'h60, a); chk("wb dev ack", 128'(a), 128'd1);
    chk("wb busy", 128'(busy), 128'd1);
    wbyte(8'h02, a); chk("wb ptr ack", 128'(a), 128'd1);
    wbyte(8'hA5, a); chk("wb d0 ack", 128'(a), 128'd1);
    wbyte(8'h3C, a); chk("wb d1 ack", 128'(a), 128'd1);
    i2c_stop(); qtr();
    chk("wb strobes", 128'(strobes - s0), 128'd2);
    chk("wb idx0", 128'(idx_log[n0]), 128'd2);
    chk("wb idx1", 128'(idx_log[n0+1]), 128'd3);
    mdl[2] = 8'hA5; mdl[3] = 8'h3C;
    chk("wb regs", regs_o, flat());
    chk("wb busy after stop", 128'(busy), 128'd0);
    for (int i = 0; i < 7; i++) begin
      s0 = strobes; n0 = idx_log.size();
      i2c_start();
      wbyte(8'h60, a); chk("wv dev ack", 128'(a), 128'd1);
      wbyte(wv[i].ptr, a); chk("wv ptr ack", 128'(a), 128'd1);
      wbyte(wv[i].data, a); chk("wv data ack", 128'(a), 128'd1);
      i2c_stop(); qtr();
      chk("wv strobes", 128'(strobes - s0), 128'(wv[i].strobe));
      if (wv[i].strobe) begin
        mdl[wv[i].ptr[3:0]] = wv[i].data;
        if (idx_log.size() > n0) chk("wv index", 128'(idx_log[n0]), 128'(wv[i].ptr));
      end
      chk("wv regs", regs_o, flat());
    end
    // read burst with repeated START
    i2c_start();
    wbyte(8'h60, a); chk("rd dev ack", 128'(a), 128'd1);
    wbyte(8'h0E, a); chk("rd ptr ack", 128'(a), 128'd1);
    i2c_start();
    wbyte(8'h61, a); chk("rd dev2 ack", 128'(a), 128'd1);
    rbyte(1'b0, d); chk("rd byte0", 128'(d), 128'h11);
    rbyte(1'b1, d); chk("rd byte1", 128'(d), 128'h22);
    i2c_stop(); qtr();
    // pointer wraps 15 -> 0 on read
    i2c_start();
    wbyte(8'h60, a);
    wbyte(8'h0F, a);
    i2c_start();
    wbyte(8'h61, a);
    rbyte(1'b0, d); chk("wrap byte15", 128'(d), 128'h22);
    rbyte(1'b1, d); chk("wrap byte0", 128'(d), 128'h12);
    i2c_stop(); qtr();
    // out-of-range read
    i2c_start();
    wbyte(8'h60, a);
    wbyte(8'h20, a); chk("oor ptr ack", 128'(a), 128'd1);
    i2c_start();
    wbyte(8'h61, a);
    rbyte(1'b1, d); chk("oor read", 128'(d), 128'hFF);
    i2c_stop(); qtr();
    // wrong address
    l0 = sda_low_cnt; b0 = busy_cnt;
    i2c_start();
    wbyte(8'h62, a); chk("wa dev nack", 128'(a), 128'd0);
    wbyte(8'h55, a); chk("wa data nack", 128'(a), 128'd0);
    i2c_stop(); qtr();
    chk("wa sda never low", 128'(sda_low_cnt - l0), 128'd0);
    chk("wa busy never", 128'(busy_cnt - b0), 128'd0);
    chk("wa regs", regs_o, flat());
    // STOP after 4 data bits
    s0 = strobes;
    i2c_start();
    wbyte(8'h60, a);
    wbyte(8'h03, a);
    for (int i = 0; i < 4; i++) bitx(1'b1, r);
    i2c_stop(); qtr();
    chk("ps strobes", 128'(strobes - s0), 128'd0);
    chk("ps regs", regs_o, flat());
    chk("ps busy", 128'(busy), 128'd0);
    // reset while target drives SDA low (reg15 = 0x22, MSB 0)
    i2c_start();
    wbyte(8'h60, a);
    wbyte(8'h0F, a);
    i2c_start();
    wbyte(8'h61, a);
    chk("mr driving low", 128'(SDA_t), 128'd0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mr SDA released", 128'(SDA_t), 128'd1);
    sda_m = 1'b1; scl = 1'b1;
    repeat (4) @(negedge clock);
    for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
    chk("mr regs", regs_o, 128'd0);
    chk("mr busy", 128'(busy), 128'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    n0 = idx_log.size();
    i2c_start();
    wbyte(8'h60, a); chk("post dev ack", 128'(a), 128'd1);
    wbyte(8'h05, a); chk("post ptr ack", 128'(a), 128'd1);
    wbyte(8'h5A, a); chk("post data ack", 128'(a), 128'd1);
    i2c_stop(); qtr();
    mdl[5] = 8'h5A;
    chk("post regs", regs_o, flat());
    chk("post strobe count", 128'(idx_log.size() - n0), 128'd1);
    if (idx_log.size() > n0) chk("post index", 128'(idx_log[n0]), 128'd5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
